// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - parametrised up/down counter/timer with four terminal-count modes
//
// Purpose: general-purpose counter for cycle counting, interval timing or
// event counting behind memory-mapped registers.
// Optional feature macro: TIMER_PRESCALE_EN (adds the prescale input and a
// prescaler that divides the enabled tick rate by prescale+1).
//
// Ports:
//   clk       in   clock, all state changes on posedge
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   load      in   load strobe (count and reload register take load_val)
//   load_val  in   load / reload value [WIDTH]
//   dir       in   1 = up, 0 = down
//   mode      in   00 wrap, 01 saturate, 10 one-shot, 11 auto-reload
//   limit     in   up-count terminal value, down-count wrap target [WIDTH]
//   clr_flag  in   clears ovf
//   prescale  in   prescaler compare value [PRESCALE_W] (TIMER_PRESCALE_EN only)
//   o         out  current count [WIDTH]
//   match     out  one-cycle pulse the cycle after a terminal tick
//   ovf       out  sticky terminal-event flag
//   running   out  1 while in RUN
module timer_counter #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic                  clr_flag,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      o,
  output logic                  match,
  output logic                  ovf,
  output logic                  running
);

  localparam logic [1:0] MODE_WRAP   = 2'b00;
  localparam logic [1:0] MODE_SAT    = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;
  localparam logic [1:0] MODE_RELOAD = 2'b11;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             match_q, match_d;
  logic             ovf_q, ovf_d;
  logic             tick_en;
  logic             tick;
  logic             terminal;

`ifdef TIMER_PRESCALE_EN
  localparam logic [PRESCALE_W-1:0] PRE_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  pre_hit;
`else
  localparam int PRE_W_UNUSED = PRESCALE_W;
`endif

  // Equality only: a count loaded above limit while counting up runs past
  // the top, wraps through zero and then reaches limit.
  assign terminal = dir ? (cnt_q == limit) : (cnt_q == '0);
  assign tick_en  = en && (state_q == S_RUN);

`ifdef TIMER_PRESCALE_EN
  assign pre_hit = (pre_q == prescale);
  assign tick    = tick_en && pre_hit;

  // The prescaler only advances on enabled RUN cycles; load restarts the phase.
  always_comb begin
    pre_d = pre_q;
    if (load) begin
      pre_d = '0;
    end else if (tick_en) begin
      pre_d = pre_hit ? '0 : pre_q + PRE_ONE;
    end
  end
`else
  assign tick = tick_en;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    match_d  = 1'b0;
    ovf_d    = clr_flag ? 1'b0 : ovf_q;

    if (load) begin
      // Load overrides any same-cycle tick and never raises match.
      cnt_d    = load_val;
      reload_d = load_val;
      state_d  = S_RUN;
    end else if (tick) begin
      if (terminal) begin
        match_d = 1'b1;
        ovf_d   = 1'b1;   // set beats a same-cycle clr_flag
        unique case (mode)
          MODE_WRAP:    cnt_d = dir ? '0 : limit;
          MODE_SAT:     cnt_d = cnt_q;
          MODE_ONESHOT: state_d = S_HALT;
          MODE_RELOAD:  cnt_d = reload_q;
          default:      cnt_d = cnt_q;
        endcase
      end else begin
        cnt_d = dir ? cnt_q + CNT_ONE : cnt_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_RUN;
      cnt_q    <= '0;
      reload_q <= '0;
      match_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      match_q  <= match_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`endif

  assign o       = cnt_q;
  assign match   = match_q;
  assign ovf     = ovf_q;
  assign running = (state_q == S_RUN);

endmodule
